// File: rtl/fp4_unpack_seq_pkg.sv
// Shared definitions for the FP4 unpack sequencer: FP4/FP9 field layout,
// FP9 exponent/mantissa codes and the sequencer state encoding.
package fp4_unpack_seq_pkg;

  localparam int FP4_W = 4;
  localparam int FP9_W = 9;

  localparam int FP4_SIGN_BIT = 3;
  localparam int FP4_EXP_MSB  = 2;
  localparam int FP4_EXP_LSB  = 1;
  localparam int FP4_MAN_BIT  = 0;

  localparam logic [4:0] EXP_ZERO     = 5'b00000;
  localparam logic [4:0] EXP_BIAS_ONE = 5'b01111;
  localparam logic [4:0] EXP_INF      = 5'b11111;
  localparam logic [2:0] NAN_MAN      = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // A single-beat word still needs a one-bit index register.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fp4_unpack_seq_fp4_to_fp9.sv
// FP4 (s,e[1:0],m) to FP9 (s,exp5,man3) converter working on one nibble of a
// byte; SELECT_HIGH picks the upper nibble.
module fp4_to_fp9
  import fp4_unpack_seq_pkg::*;
#(
  parameter bit SELECT_HIGH = 1'b0
) (
  input  logic [7:0]       byte_i,
  output logic [FP9_W-1:0] fp9_o,
  output logic             invalid_o,
  output logic             underflow_o,
  output logic             overflow_o
);

  logic [FP4_W-1:0] nib;
  logic             sgn;
  logic [1:0]       expo;
  logic             man;

  assign nib  = SELECT_HIGH ? byte_i[7:4] : byte_i[3:0];
  assign sgn  = nib[FP4_SIGN_BIT];
  assign expo = nib[FP4_EXP_MSB:FP4_EXP_LSB];
  assign man  = nib[FP4_MAN_BIT];

  // e=10 has no finite FP9 image here and saturates to Inf; e=11 with m=1 is NaN.
  always_comb begin
    fp9_o       = '0;
    invalid_o   = 1'b0;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    unique case (expo)
      2'b00: fp9_o = {sgn, EXP_ZERO, man, 2'b00};
      2'b01: fp9_o = {sgn, EXP_BIAS_ONE, man, 2'b00};
      2'b10: begin
        fp9_o      = {sgn, EXP_INF, 3'b000};
        overflow_o = 1'b1;
      end
      2'b11: begin
        if (man) begin
          fp9_o     = {sgn, EXP_INF, NAN_MAN};
          invalid_o = 1'b1;
        end else begin
          fp9_o = {sgn, EXP_INF, 3'b000};
        end
      end
      default: fp9_o = '0;
    endcase
  end

endmodule

// File: rtl/fp4_unpack_seq.sv
// Streaming sequencer: accepts one packed FP4 word, then presents it one byte
// (two FP9 elements) per beat with per-beat and per-word NaN status.
module fp4_unpack_seq
  import fp4_unpack_seq_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*FP9_W-1:0]   out_fp9,
  output logic                 out_invalid,
  output logic                 out_last,
  output logic                 out_word_invalid
);

  localparam int BEATS = IN_W / 8;
  localparam int IDX_W = idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  seq_state_e       state_q, state_d;
  logic [IN_W-1:0]  buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sticky_q, sticky_d;

  logic             run;
  logic             in_fire;
  logic             out_fire;
  logic [7:0]       beat_byte;
  logic [FP9_W-1:0] fp9_lo, fp9_hi;
  logic             inv_lo, inv_hi;
  logic             unused_uf_lo, unused_uf_hi, unused_of_lo, unused_of_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      sticky_q <= sticky_d;
    end
  end

  // Flush outranks everything; in_fire on the last beat restarts at beat 0 with no bubble.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    sticky_d = sticky_q;
    if (flush) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      sticky_d = 1'b0;
    end else if (in_fire) begin
      state_d  = ST_RUN;
      buf_d    = in_data;
      idx_d    = '0;
      sticky_d = 1'b0;
    end else if (out_fire) begin
      if (out_last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d    = idx_q + IDX_W'(1);
        sticky_d = sticky_q | out_invalid;
      end
    end
  end

  always_comb begin
    run              = (state_q == ST_RUN);
    out_valid        = rst_n & run;
    out_last         = run & (idx_q == LAST_IDX);
    in_ready         = rst_n & ~flush & (~run | (out_last & out_ready));
    in_fire          = in_valid & in_ready;
    out_fire         = out_valid & out_ready;
    out_invalid      = inv_lo | inv_hi;
    out_fp9          = {fp9_hi, fp9_lo};
    out_word_invalid = out_last & (sticky_q | out_invalid);
  end

  always_comb begin
    beat_byte = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (idx_q == b[IDX_W-1:0]) beat_byte = buf_q[8*b +: 8];
    end
  end

  fp4_to_fp9 #(.SELECT_HIGH(1'b0)) u_conv_lo (
    .byte_i      (beat_byte),
    .fp9_o       (fp9_lo),
    .invalid_o   (inv_lo),
    .underflow_o (unused_uf_lo),
    .overflow_o  (unused_of_lo)
  );

  fp4_to_fp9 #(.SELECT_HIGH(1'b1)) u_conv_hi (
    .byte_i      (beat_byte),
    .fp9_o       (fp9_hi),
    .invalid_o   (inv_hi),
    .underflow_o (unused_uf_hi),
    .overflow_o  (unused_of_hi)
  );

endmodule

// File: tb/tb_fp4_unpack_seq.sv
// Directed self-checking bench for fp4_unpack_seq with hand-computed FP9 beats.
module tb_fp4_unpack_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_fp9;
  logic        out_invalid;
  logic        out_last;
  logic        out_word_invalid;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  localparam logic [31:0] WORD_A = 32'h7F21_3A0B;
  localparam logic [31:0] WORD_B = 32'h0000_0084;
  localparam logic [31:0] WORD_C = 32'h0000_00F0;

  logic [17:0] expA[4] = '{18'h0017C, 18'h0F978, 18'h0F004, 18'h1F3F9};
  logic        invA[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [17:0] expB[4] = '{18'h200F8, 18'h00000, 18'h00000, 18'h00000};
  logic [17:0] expC[4] = '{18'h3F200, 18'h00000, 18'h00000, 18'h00000};
  logic        invC[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  fp4_unpack_seq #(.IN_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_fp9          (out_fp9),
    .out_invalid      (out_invalid),
    .out_last         (out_last),
    .out_word_invalid (out_word_invalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rstN, input logic fl, input logic iv,
                               input logic [31:0] d, input logic ordy);
    rst_n     = rstN;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [17:0] fp9, input logic inv,
                           input logic last, input logic winv);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_fp9"}, 32'(out_fp9), 32'(fp9));
    checkOutput({tag, "_inv"}, 32'(out_invalid), 32'(inv));
    checkOutput({tag, "_last"}, 32'(out_last), 32'(last));
    checkOutput({tag, "_winv"}, 32'(out_word_invalid), 32'(winv));
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Word conversion with NaN in the last beat
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_A, 1'b1);
    checkOutput("A_accept_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkBeat($sformatf("A_b%0d", b), expA[b], invA[b], b == 3, b == 3);
      checkOutput($sformatf("A_b%0d_in_ready", b), 32'(in_ready), 32'(b == 3));
      tick();
    end
    checkOutput("A_idle", 32'(out_valid), 32'd0);

    // Saturation to Inf and negative zero, no NaN
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_B, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkBeat($sformatf("B_b%0d", b), expB[b], 1'b0, b == 3, 1'b0);
      tick();
    end
    checkOutput("B_idle", 32'(out_valid), 32'd0);

    // Backpressure: three stalled cycles on beat 1
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_A, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkBeat("bp_b0", expA[0], 1'b0, 1'b0, 1'b0);
    if (out_valid && out_ready) fires++;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkBeat($sformatf("bp_hold%0d", s), expA[1], 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("bp_hold%0d_in_ready", s), 32'(in_ready), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 1; b < 4; b++) begin
      checkBeat($sformatf("bp_b%0d", b), expA[b], invA[b], b == 3, b == 3);
      if (out_valid && out_ready) fires++;
      tick();
    end
    checkOutput("bp_fires", 32'(fires), 32'd4);
    checkOutput("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back words with in_valid held high
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_A, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_B, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkBeat($sformatf("b2b_A_b%0d", b), expA[b], invA[b], b == 3, b == 3);
      checkOutput($sformatf("b2b_A_b%0d_in_ready", b), 32'(in_ready), 32'(b == 3));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkBeat($sformatf("b2b_B_b%0d", b), expB[b], 1'b0, b == 3, 1'b0);
      tick();
    end
    checkOutput("b2b_idle", 32'(out_valid), 32'd0);

    // Flush at beat 2 of a word whose beat 0 is NaN, with a new word offered
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_C, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      checkBeat($sformatf("fl_C_b%0d", b), expC[b], invC[b], 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, WORD_B, 1'b1);
    checkOutput("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_B, 1'b1);
    checkOutput("fl_after_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_after_in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkBeat($sformatf("fl_B_b%0d", b), expB[b], 1'b0, b == 3, 1'b0);
      tick();
    end

    // Flush while idle changes nothing
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("idle_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_flush_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a word
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_A, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkBeat("rm_b0", expA[0], 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rm_in_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("rm_in_reset_in_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rm_after_valid", 32'(out_valid), 32'd0);
    checkOutput("rm_after_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, WORD_B, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkBeat("rm_new_b0", expB[0], 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
